// File: rtl/pipeline_hazard_ctrl.sv
// Stall/sequencing controller for the 5-stage core: EX/MEM/WB writer scoreboard, MUL sequencer,
// stage enables, bubble injection and bypass selects. Optional bypass network: HAZARD_BYPASS_EN.
module pipeline_hazard_ctrl #(
  parameter int unsigned MUL_LAT = 5,
  parameter logic [6:0]  NOP_OP  = 7'h3F
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [6:0] id_opcode,
  input  logic [4:0] id_src1,
  input  logic [4:0] id_src2,
  input  logic [4:0] id_dst,
  output logic       if_en,
  output logic       id_en,
  output logic       ex_en,
  output logic       ex_bubble,
  output logic       mem_bubble,
  output logic [1:0] fwd1_sel,
  output logic [1:0] fwd2_sel,
  output logic       mult_busy,
  output logic       mult_done
);

  localparam int unsigned CW = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;

  localparam logic [6:0] OP_ADD = 7'h00;
  localparam logic [6:0] OP_SUB = 7'h01;
  localparam logic [6:0] OP_MUL = 7'h02;
  localparam logic [6:0] OP_LDB = 7'h10;
  localparam logic [6:0] OP_LDW = 7'h11;

  typedef enum logic [1:0] {IDLE, MUL_BUSY, MUL_DONE} state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic       is_load;
  } sb_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  sb_t           sb_ex, sb_mem, sb_wb;
  sb_t           dec;
  logic          load_use, raw, stall, advance, mul_issue;

  function automatic logic hit(input sb_t e, input logic [4:0] s);
    return e.valid && (e.dst != '0) && (e.dst == s);
  endfunction

  always_comb begin
    dec         = '0;
    dec.is_load = (id_opcode == OP_LDB) || (id_opcode == OP_LDW);
    dec.dst     = id_dst;
    dec.valid   = (id_opcode != NOP_OP) &&
                  ((id_opcode == OP_ADD) || (id_opcode == OP_SUB) ||
                   (id_opcode == OP_MUL) || dec.is_load);
  end

  always_comb begin
    load_use = id_valid && sb_ex.is_load && (hit(sb_ex, id_src1) || hit(sb_ex, id_src2));
`ifdef HAZARD_BYPASS_EN
    raw = load_use;
`else
    raw = id_valid && (hit(sb_ex, id_src1)  || hit(sb_ex, id_src2)  ||
                       hit(sb_mem, id_src1) || hit(sb_mem, id_src2) ||
                       hit(sb_wb, id_src1)  || hit(sb_wb, id_src2));
`endif
    stall = (state != MUL_BUSY) && raw;
  end

  // State and counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign advance   = id_valid && id_en && !ex_bubble;
  assign mul_issue = advance && (id_opcode == OP_MUL);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      MUL_BUSY: begin
        if (cnt == '0) state_nxt = MUL_DONE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: begin
        if (mul_issue) begin
          state_nxt = MUL_BUSY;
          cnt_nxt   = CW'(MUL_LAT - 2);
        end else begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    if_en      = 1'b1;
    id_en      = 1'b1;
    ex_en      = 1'b1;
    ex_bubble  = 1'b0;
    mem_bubble = 1'b0;
    mult_busy  = 1'b0;
    mult_done  = 1'b0;
    case (state)
      MUL_BUSY: begin
        if_en      = 1'b0;
        id_en      = 1'b0;
        mem_bubble = 1'b1;
        mult_busy  = 1'b1;
      end
      MUL_DONE: mult_done = 1'b1;
      default: ;
    endcase
    if (stall) begin
      if_en     = 1'b0;
      id_en     = 1'b0;
      ex_bubble = 1'b1;
    end
  end

`ifdef HAZARD_BYPASS_EN
  // Loads in MEM have no EX result to forward; they are only picked up from WB
  function automatic logic [1:0] sel_for(input sb_t m, input sb_t w, input logic [4:0] s);
    if (hit(m, s) && !m.is_load) return 2'b01;
    if (hit(w, s))               return 2'b10;
    return 2'b00;
  endfunction

  assign fwd1_sel = sel_for(sb_mem, sb_wb, id_src1);
  assign fwd2_sel = sel_for(sb_mem, sb_wb, id_src2);
`else
  assign fwd1_sel = 2'b00;
  assign fwd2_sel = 2'b00;
`endif

  // While the MUL occupies EX its slot is frozen and MEM receives bubbles behind it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_ex  <= '0;
      sb_mem <= '0;
      sb_wb  <= '0;
    end else if (state == MUL_BUSY) begin
      sb_mem <= '0;
      sb_wb  <= sb_mem;
    end else begin
      sb_ex  <= advance ? dec : '0;
      sb_mem <= sb_ex;
      sb_wb  <= sb_mem;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic against an in-flight
// instruction model. Expectations follow HAZARD_BYPASS_EN when it is defined.
module tb_pipeline_hazard_ctrl;

  localparam int MUL_LAT = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [6:0] id_opcode;
  logic [4:0] id_src1, id_src2, id_dst;
  logic       if_en, id_en, ex_en, ex_bubble, mem_bubble, mult_busy, mult_done;
  logic [1:0] fwd1_sel, fwd2_sel;

  int vectors = 0;
  int miscompares = 0;

  pipeline_hazard_ctrl #(.MUL_LAT(MUL_LAT), .NOP_OP(7'h3F)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_src1(id_src1), .id_src2(id_src2), .id_dst(id_dst),
    .if_en(if_en), .id_en(id_en), .ex_en(ex_en), .ex_bubble(ex_bubble),
    .mem_bubble(mem_bubble), .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel),
    .mult_busy(mult_busy), .mult_done(mult_done)
  );

  always #5 clk = ~clk;

  // Model: index 0 = in EX, 1 = in MEM, 2 = in WB
  bit         m_v[3];
  logic [4:0] m_d[3];
  bit         m_l[3];
  int         m_busy_left;
  bit         m_done;
  bit         e_busy, e_stall, e_if, e_exb, e_memb, e_done;
  logic [1:0] e_fwd1, e_fwd2;

  function automatic bit writes(input logic [6:0] op);
    return op == 7'h00 || op == 7'h01 || op == 7'h02 || op == 7'h10 || op == 7'h11;
  endfunction

`ifdef HAZARD_BYPASS_EN
  function automatic logic [1:0] fwd_of(input logic [4:0] s);
    if (m_v[1] && !m_l[1] && m_d[1] != 0 && m_d[1] == s) return 2'b01;
    if (m_v[2] && m_d[2] != 0 && m_d[2] == s) return 2'b10;
    return 2'b00;
  endfunction
`endif

  task automatic model_reset;
    for (int i = 0; i < 3; i++) begin
      m_v[i] = 0; m_d[i] = '0; m_l[i] = 0;
    end
    m_busy_left = 0;
    m_done = 0;
  endtask

  task automatic model_eval;
    bit hz;
    hz = 0;
    e_busy = (m_busy_left > 0);
    if (id_valid)
      for (int i = 0; i < 3; i++)
        if (m_v[i] && m_d[i] != 0 && (m_d[i] == id_src1 || m_d[i] == id_src2)) begin
`ifdef HAZARD_BYPASS_EN
          if (i == 0 && m_l[0]) hz = 1;
`else
          hz = 1;
`endif
        end
    e_stall = !e_busy && hz;
    e_if    = !e_busy && !e_stall;
    e_exb   = e_stall;
    e_memb  = e_busy;
    e_done  = m_done;
`ifdef HAZARD_BYPASS_EN
    e_fwd1 = fwd_of(id_src1);
    e_fwd2 = fwd_of(id_src2);
`else
    e_fwd1 = 2'b00;
    e_fwd2 = 2'b00;
`endif
  endtask

  task automatic model_clock;
    bit adv;
    adv = id_valid && !e_busy && !e_stall;
    m_v[2] = m_v[1]; m_d[2] = m_d[1]; m_l[2] = m_l[1];
    if (e_busy) begin
      m_v[1] = 0;
      m_busy_left--;
      m_done = (m_busy_left == 0);
    end else begin
      m_v[1] = m_v[0]; m_d[1] = m_d[0]; m_l[1] = m_l[0];
      m_v[0] = adv && writes(id_opcode);
      m_d[0] = id_dst;
      m_l[0] = (id_opcode == 7'h10 || id_opcode == 7'h11);
      m_done = 0;
      if (adv && id_opcode == 7'h02) m_busy_left = MUL_LAT - 1;
    end
  endtask

  task automatic drive(input bit v, input logic [6:0] op, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [4:0] d);
    id_valid = v; id_opcode = op; id_src1 = s1; id_src2 = s2; id_dst = d;
  endtask

  task automatic settle;
    @(negedge clk);
    model_eval();
  endtask

  task automatic tick;
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic drain(input int n);
    drive(0, 7'h3F, 0, 0, 0);
    repeat (n) begin settle(); tick(); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(0, 7'h3F, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    settle();
    vectors++;
    if ({if_en, id_en, ex_en, ex_bubble, mem_bubble} !== 5'b11100) begin
      miscompares++;
      $display("FAIL reset_enables: got %b want 11100", {if_en, id_en, ex_en, ex_bubble, mem_bubble});
    end
    vectors++;
    if ({fwd1_sel, fwd2_sel, mult_busy, mult_done} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_fwd_mul: got %b want 000000", {fwd1_sel, fwd2_sel, mult_busy, mult_done});
    end
    tick();
  endtask

  task automatic test_mul;
    int n_if = 0, n_mb = 0;
    bit done5 = 0;
    drain(6);
    drive(1, 7'h02, 1, 2, 7);
    settle();
    vectors++;
    if (if_en !== 1'b1) begin
      miscompares++; $display("FAIL mul_issue_if_en: got %b want 1", if_en);
    end
    tick();
    drive(1, 7'h02, 1, 2, 9);
    for (int c = 1; c <= 5; c++) begin
      settle();
      if (if_en === 1'b0) n_if++;
      if (mem_bubble === 1'b1) n_mb++;
      if (c == 5) done5 = (mult_done === 1'b1);
      tick();
    end
    vectors++;
    if (n_if != MUL_LAT - 1) begin
      miscompares++; $display("FAIL mul_if_hold: got %0d cycles want %0d", n_if, MUL_LAT - 1);
    end
    vectors++;
    if (n_mb != MUL_LAT - 1) begin
      miscompares++; $display("FAIL mul_mem_bubble: got %0d cycles want %0d", n_mb, MUL_LAT - 1);
    end
    vectors++;
    if (!done5) begin
      miscompares++; $display("FAIL mul_done_cycle: no pulse on cycle %0d", MUL_LAT);
    end
    drive(0, 7'h3F, 0, 0, 0);
    settle();
    vectors++;
    if (mult_busy !== 1'b1) begin
      miscompares++; $display("FAIL mul_back_to_back: mult_busy got %b want 1", mult_busy);
    end
    tick();
    drain(8);
  endtask

  task automatic test_raw;
    int stalls = 0;
`ifdef HAZARD_BYPASS_EN
    int want = 0;
    logic [1:0] want_fwd = 2'b01;
`else
    int want = 3;
    logic [1:0] want_fwd = 2'b00;
`endif
    drain(4);
    drive(1, 7'h00, 1, 2, 3); settle(); tick();
    drive(1, 7'h00, 3, 1, 4);
    for (int c = 0; c < 10; c++) begin
      settle();
      if (if_en === 1'b1) break;
      stalls++;
      tick();
    end
    vectors++;
    if (stalls != want) begin
      miscompares++; $display("FAIL raw_stall_count: got %0d want %0d", stalls, want);
    end
    vectors++;
    if (stalls == 3 && fwd1_sel !== 2'b00) begin
      miscompares++; $display("FAIL raw_fwd_after_stall: got %b want 00", fwd1_sel);
    end
    tick();
    drain(4);
    drive(1, 7'h00, 1, 2, 3); settle(); tick();
    drive(1, 7'h00, 1, 2, 8); settle(); tick();
    drive(1, 7'h00, 3, 1, 4); settle();
    vectors++;
    if (fwd1_sel !== want_fwd || fwd2_sel !== 2'b00) begin
      miscompares++;
      $display("FAIL raw_fwd_from_mem: got %b/%b want %b/00", fwd1_sel, fwd2_sel, want_fwd);
    end
    tick();
    drain(4);
  endtask

  task automatic test_load_use;
    int n_if = 0, n_bub = 0;
`ifdef HAZARD_BYPASS_EN
    int want = 1;
`else
    int want = 3;
`endif
    drain(4);
    drive(1, 7'h11, 1, 2, 5); settle(); tick();
    drive(1, 7'h01, 5, 5, 6);
    for (int c = 0; c < 10; c++) begin
      settle();
      if (ex_bubble === 1'b1) n_bub++;
      if (if_en === 1'b1) break;
      n_if++;
      tick();
    end
    vectors++;
    if (n_if != want) begin
      miscompares++; $display("FAIL load_use_if_hold: got %0d want %0d", n_if, want);
    end
    vectors++;
    if (n_bub != want) begin
      miscompares++; $display("FAIL load_use_bubble: got %0d want %0d", n_bub, want);
    end
    tick();
    drain(4);
  endtask

  task automatic test_r0_store;
    drain(4);
    drive(1, 7'h00, 1, 2, 0); settle(); tick();
    drive(1, 7'h00, 0, 0, 2); settle();
    vectors++;
    if (if_en !== 1'b1 || ex_bubble !== 1'b0 || fwd1_sel !== 2'b00 || fwd2_sel !== 2'b00) begin
      miscompares++;
      $display("FAIL r0_no_hazard: if_en=%b bub=%b fwd=%b/%b want 1 0 00/00",
               if_en, ex_bubble, fwd1_sel, fwd2_sel);
    end
    tick();
    drive(1, 7'h13, 1, 2, 5); settle(); tick();
    drive(1, 7'h11, 5, 5, 5); settle();
    vectors++;
    if (if_en !== 1'b1 || ex_bubble !== 1'b0) begin
      miscompares++;
      $display("FAIL store_no_hazard: if_en=%b bub=%b want 1 0", if_en, ex_bubble);
    end
    tick();
    drain(4);
  endtask

  task automatic test_reset_mid_mul;
    drain(4);
    drive(1, 7'h02, 1, 2, 7); settle(); tick();
    drive(1, 7'h00, 7, 7, 8);
    settle(); tick();
    settle();
    vectors++;
    if (mult_busy !== 1'b1) begin
      miscompares++; $display("FAIL mid_mul_busy: got %b want 1", mult_busy);
    end
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (mult_busy !== 1'b0 || if_en !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset_outputs: busy=%b if_en=%b want 0 1", mult_busy, if_en);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    settle();
    vectors++;
    if (if_en !== 1'b1 || mult_busy !== 1'b0 || ex_bubble !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_slots: if_en=%b busy=%b bub=%b want 1 0 0", if_en, mult_busy, ex_bubble);
    end
    tick();
    drain(8);
  endtask

  task automatic test_random;
    logic [6:0] ops[8] = '{7'h00, 7'h01, 7'h02, 7'h10, 7'h11, 7'h12, 7'h13, 7'h3F};
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 3) != 0, ops[$urandom_range(0, 7)],
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      settle();
      vectors++;
      if ({if_en, id_en, ex_en, ex_bubble, mem_bubble, mult_busy, mult_done} !==
          {e_if, e_if, 1'b1, e_exb, e_memb, e_busy, e_done}) begin
        miscompares++;
        $display("FAIL rand_ctrl cycle %0d: got %b want %b", c,
                 {if_en, id_en, ex_en, ex_bubble, mem_bubble, mult_busy, mult_done},
                 {e_if, e_if, 1'b1, e_exb, e_memb, e_busy, e_done});
      end
      vectors++;
      if (fwd1_sel !== e_fwd1 || fwd2_sel !== e_fwd2) begin
        miscompares++;
        $display("FAIL rand_fwd cycle %0d: got %b/%b want %b/%b", c, fwd1_sel, fwd2_sel, e_fwd1, e_fwd2);
      end
      tick();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_mul();
    test_raw();
    test_load_use();
    test_r0_store();
    test_reset_mid_mul();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
